// File: rtl/seg7_pkg.sv
// Seven-segment pattern table shared by the encoder and decoder sides of the link.
// Bit order is {a,b,c,d,e,f,g}; a 1 lights the segment.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic       legal;
    logic [3:0] nibble;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] pattern);
    seg7_dec_t r;
    r.legal  = 1'b1;
    r.nibble = 4'h0;
    case (pattern)
      SEG_0:   r.nibble = 4'h0;
      SEG_1:   r.nibble = 4'h1;
      SEG_2:   r.nibble = 4'h2;
      SEG_3:   r.nibble = 4'h3;
      SEG_4:   r.nibble = 4'h4;
      SEG_5:   r.nibble = 4'h5;
      SEG_6:   r.nibble = 4'h6;
      SEG_7:   r.nibble = 4'h7;
      SEG_8:   r.nibble = 4'h8;
      SEG_9:   r.nibble = 4'h9;
      SEG_A:   r.nibble = 4'hA;
      SEG_B:   r.nibble = 4'hB;
      SEG_C:   r.nibble = 4'hC;
      SEG_D:   r.nibble = 4'hD;
      SEG_E:   r.nibble = 4'hE;
      SEG_F:   r.nibble = 4'hF;
      default: r.legal  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_segm_decoder_if.sv
// Segment-in / digit-out bundle of the seven-segment receive side.
interface seven_segm_decoder_if;

  logic [6:0] ssd_leds;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       pattern_err;
  logic [7:0] err_count;

  modport master (
    output ssd_leds,
    input  digit, digit_valid, blank, pattern_err, err_count
  );

  modport slave (
    input  ssd_leds,
    output digit, digit_valid, blank, pattern_err, err_count
  );

endinterface

// File: rtl/seg7_sync.sv
// Two-flop synchroniser for a bus whose bits only matter once they have settled.
module seg7_sync #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // NOTE: registers use non-blocking assignment so s1->s2 forms two stages, not a wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/seven_segm_decoder.sv
// Seven-segment receiver: waits for a stable synced pattern, then decodes it once
// into a hex digit, a blank flag, or an illegal-pattern pulse with a saturating count.
module seven_segm_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input logic                 clk,
  input logic                 rst,
  seven_segm_decoder_if.slave bus
);

  localparam logic [0:0] TRACK  = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // The sample that reveals a change is already the first of the new run.
  localparam logic [CNT_W-1:0] CNT_START = (STABLE_CYCLES > 1) ? CNT_W'(1) : '0;
  localparam logic [CNT_W-1:0] CNT_LOCK  = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       synced;
  logic [6:0]       prev;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  seg7_dec_t        dec;

  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       pattern_err;
  logic [7:0] err_count;

  seg7_sync #(.WIDTH(7)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.ssd_leds),
    .q   (synced)
  );

  assign dec = seg7_decode(synced);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev        <= '0;
      state       <= TRACK;
      cnt         <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      blank       <= 1'b0;
      pattern_err <= 1'b0;
      err_count   <= '0;
    end else begin
      prev        <= synced;
      digit_valid <= 1'b0;
      pattern_err <= 1'b0;
      if (synced != prev) begin
        cnt   <= CNT_START;
        state <= TRACK;
      end else if (state == TRACK) begin
        if (cnt == CNT_LOCK) begin
          state <= LOCKED;
          if (synced == SEG_BLANK) begin
            blank <= 1'b1;
          end else if (dec.legal) begin
            digit       <= dec.nibble;
            digit_valid <= 1'b1;
            blank       <= 1'b0;
          end else begin
            pattern_err <= 1'b1;
            blank       <= 1'b0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.digit       = digit;
  assign bus.digit_valid = digit_valid;
  assign bus.blank       = blank;
  assign bus.pattern_err = pattern_err;
  assign bus.err_count   = err_count;

endmodule

// File: tb/tb_seven_segm_decoder.sv
// Directed bench for the seven-segment receiver with STABLE_CYCLES = 4.
module tb_seven_segm_decoder;
  import seg7_pkg::*;

  logic clk;
  logic rst;
  seven_segm_decoder_if bus ();

  seven_segm_decoder #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Pulse monitor, sampled on the falling edge.
  int         dv_cnt   = 0;
  int         pe_cnt   = 0;
  int         both_cnt = 0;
  logic [3:0] dv_digits[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.digit_valid) begin
        dv_cnt++;
        dv_digits.push_back(bus.digit);
      end
      if (bus.pattern_err) pe_cnt++;
      if (bus.digit_valid && bus.pattern_err) both_cnt++;
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [6:0] v);
    @(negedge clk);
    bus.ssd_leds = v;
  endtask

  task automatic cmp(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ssd_leds = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset digit", int'(bus.digit), 0);
    cmp("reset digit_valid", int'(bus.digit_valid), 0);
    cmp("reset blank", int'(bus.blank), 0);
    cmp("reset pattern_err", int'(bus.pattern_err), 0);
    cmp("reset err_count", int'(bus.err_count), 0);
  endtask

  task automatic test_single_decode();
    int base;
    @(negedge clk);
    bus.ssd_leds = SEG_1;
    rst = 1'b0;
    base = dv_cnt;
    for (int e = 1; e <= 5; e++) begin
      edge1();
      cmp($sformatf("single no early pulse edge %0d", e), int'(bus.digit_valid), 0);
    end
    edge1();
    cmp("single pulse at k+5", int'(bus.digit_valid), 1);
    cmp("single digit", int'(bus.digit), 1);
    edge1();
    cmp("single pulse width", int'(bus.digit_valid), 0);
    repeat (50) @(posedge clk);
    #1;
    cmp("single pulse count over 50 cycles", dv_cnt - base, 1);
  endtask

  task automatic test_sweep();
    logic [6:0] tbl[16];
    int base_dv, base_pe;
    tbl = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
            SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
    dv_digits.delete();
    base_dv = dv_cnt;
    base_pe = pe_cnt;
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      repeat (10) @(posedge clk);
    end
    #1;
    cmp("sweep pulse count", dv_cnt - base_dv, 16);
    cmp("sweep pattern_err count", pe_cnt - base_pe, 0);
    for (int i = 0; i < 16; i++) begin
      if (i < dv_digits.size())
        cmp($sformatf("sweep digit %0d", i), int'(dv_digits[i]), i);
      else
        cmp($sformatf("sweep digit %0d missing", i), -1, i);
    end
  endtask

  task automatic test_glitch();
    int base;
    dv_digits.delete();
    base = dv_cnt;
    apply(SEG_0);
    @(negedge clk);
    bus.ssd_leds = SEG_1;
    repeat (20) @(posedge clk);
    #1;
    cmp("glitch pulse count", dv_cnt - base, 1);
    cmp("glitch digit", int'(bus.digit), 1);
    if (dv_digits.size() > 0) cmp("glitch pulsed digit", int'(dv_digits[0]), 1);
    else cmp("glitch pulsed digit missing", -1, 1);
  endtask

  task automatic test_err_saturate();
    int base_pe, base_dv;
    base_pe = pe_cnt;
    base_dv = dv_cnt;
    for (int i = 1; i <= 300; i++) begin
      apply(7'h01);
      repeat (10) @(posedge clk);
      apply(SEG_BLANK);
      repeat (10) @(posedge clk);
      #1;
      if (i == 1)   cmp("err_count after 1", int'(bus.err_count), 1);
      if (i == 254) cmp("err_count after 254", int'(bus.err_count), 254);
      if (i == 255) cmp("err_count after 255", int'(bus.err_count), 255);
      if (i == 256) cmp("err_count after 256 saturates", int'(bus.err_count), 255);
    end
    cmp("err pulse count", pe_cnt - base_pe, 300);
    cmp("err no digit pulses", dv_cnt - base_dv, 0);
    cmp("err digit held", int'(bus.digit), 1);
    cmp("err_count final", int'(bus.err_count), 255);
  endtask

  task automatic test_blank();
    int base;
    apply(SEG_3);
    repeat (10) @(posedge clk);
    #1;
    cmp("blank pre digit", int'(bus.digit), 3);
    cmp("blank pre flag", int'(bus.blank), 0);
    base = dv_cnt;
    apply(SEG_BLANK);
    repeat (5) edge1();
    cmp("blank not yet", int'(bus.blank), 0);
    edge1();
    cmp("blank rises", int'(bus.blank), 1);
    repeat (10) @(posedge clk);
    #1;
    cmp("blank held", int'(bus.blank), 1);
    cmp("blank no digit pulse", dv_cnt - base, 0);
    cmp("blank digit held", int'(bus.digit), 3);
    apply(SEG_8);
    repeat (5) edge1();
    cmp("unblank not yet", int'(bus.blank), 1);
    edge1();
    cmp("unblank flag", int'(bus.blank), 0);
    cmp("unblank pulse", int'(bus.digit_valid), 1);
    cmp("unblank digit", int'(bus.digit), 8);
  endtask

  task automatic test_reset_mid();
    apply(SEG_3);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    cmp("mid reset digit", int'(bus.digit), 0);
    cmp("mid reset err_count", int'(bus.err_count), 0);
    cmp("mid reset blank", int'(bus.blank), 0);
    cmp("mid reset digit_valid", int'(bus.digit_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      edge1();
      cmp($sformatf("post reset no pulse edge %0d", e), int'(bus.digit_valid), 0);
    end
    edge1();
    cmp("post reset pulse", int'(bus.digit_valid), 1);
    cmp("post reset digit", int'(bus.digit), 3);
  endtask

  initial begin
    test_reset();
    test_single_decode();
    test_sweep();
    test_glitch();
    test_err_saturate();
    test_blank();
    test_reset_mid();
    cmp("digit_valid and pattern_err overlap", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
